// File: rtl/ttt_game_sequencer.sv
// ttt_game_sequencer
//   Tic-tac-toe turn/board sequencer. It debounces the select button and
//   commits the current player's mark to the square under the cursor. It then
//   alternates turns, detects a win or a draw, and produces the four SSD
//   nibbles.
//
//   Optional feature macro: TTT_SCORE_EN. When it is defined, the block keeps
//   saturating 4-bit win tallies per player and shows them on ssd3.
//
//   Ports:
//     ClkPort     in   system clock
//     Reset       in   asynchronous, active-high reset
//     btn_sel     in   raw select button (asynchronous, bouncy)
//     cursor      in   [3:0] square 0..8 (9..15 invalid)
//     board       out  [17:0] cell i at [2i+1:2i]: 00 empty, 01 X, 10 O
//     turn        out  0 = X to move, 1 = O to move
//     game_state  out  [1:0] 00 PLAY, 01 CHECK, 10 WIN, 11 DRAW
//     winner      out  [1:0] 00 none, 01 X, 10 O
//     win_line    out  [7:0] rows 0-2, cols 3-5, diag 6, anti-diag 7
//     ssd3..ssd0  out  [3:0] display nibbles
module ttt_game_sequencer #(
    parameter int DB_CYCLES = 1_000_000,
    parameter int DB_W      = 20
) (
    input  logic        ClkPort,
    input  logic        Reset,
    input  logic        btn_sel,
    input  logic [3:0]  cursor,
    output logic [17:0] board,
    output logic        turn,
    output logic [1:0]  game_state,
    output logic [1:0]  winner,
    output logic [7:0]  win_line,
    output logic [3:0]  ssd3,
    output logic [3:0]  ssd2,
    output logic [3:0]  ssd1,
    output logic [3:0]  ssd0
);

    typedef enum logic [1:0] {
        S_PLAY  = 2'b00,
        S_CHECK = 2'b01,
        S_WIN   = 2'b10,
        S_DRAW  = 2'b11
    } state_t;

    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

    // ---------------- button synchronizer + debounce ----------------
    logic            sync1, sync2, stable, sel_pulse;
    logic [DB_W-1:0] db_cnt;

    always_ff @(posedge ClkPort or posedge Reset) begin
        if (Reset) begin
            sync1     <= 1'b0;
            sync2     <= 1'b0;
            stable    <= 1'b0;
            db_cnt    <= '0;
            sel_pulse <= 1'b0;
        end else begin
            sync1     <= btn_sel;
            sync2     <= sync1;
            // Only a rising edge of the debounced level strobes.
            // Releases update `stable` silently.
            sel_pulse <= sync2 && !stable && (db_cnt == DB_LAST);
            if (sync2 != stable) begin
                if (db_cnt == DB_LAST) begin
                    stable <= sync2;
                    db_cnt <= '0;
                end else begin
                    db_cnt <= db_cnt + 1'b1;
                end
            end else begin
                db_cnt <= '0;
            end
        end
    end

    // ---------------- line evaluation ----------------
    // Return the k-th cell (k = 0..2) of winning line l.
    function automatic int line_cell(input int l, input int k);
        logic [11:0] t;
        case (l)
            0:       t = {4'd2, 4'd1, 4'd0};
            1:       t = {4'd5, 4'd4, 4'd3};
            2:       t = {4'd8, 4'd7, 4'd6};
            3:       t = {4'd6, 4'd3, 4'd0};
            4:       t = {4'd7, 4'd4, 4'd1};
            5:       t = {4'd8, 4'd5, 4'd2};
            6:       t = {4'd8, 4'd4, 4'd0};
            default: t = {4'd6, 4'd4, 4'd2};
        endcase
        return int'(t[4*k +: 4]);
    endfunction

    state_t      state, state_n;
    logic [17:0] board_n;
    logic        turn_n;
    logic [1:0]  winner_n;
    logic [7:0]  win_line_n, line_hit;
    logic [8:0]  cell_full;
    logic [1:0]  mark;
    logic        cursor_ok;

    // During CHECK, `turn` still identifies the player who just moved.
    assign mark      = turn ? 2'b10 : 2'b01;
    assign cursor_ok = (cursor <= 4'd8);

    for (genvar c = 0; c < 9; c++) begin : g_cell
        assign cell_full[c] = |board[2*c +: 2];
    end

    for (genvar l = 0; l < 8; l++) begin : g_line
        localparam int C0 = line_cell(l, 0);
        localparam int C1 = line_cell(l, 1);
        localparam int C2 = line_cell(l, 2);
        assign line_hit[l] = (board[2*C0 +: 2] == mark) &&
                             (board[2*C1 +: 2] == mark) &&
                             (board[2*C2 +: 2] == mark);
    end

    // ---------------- FSM ----------------
    always_ff @(posedge ClkPort or posedge Reset) begin
        if (Reset) begin
            state    <= S_PLAY;
            board    <= '0;
            turn     <= 1'b0;
            winner   <= 2'b00;
            win_line <= '0;
        end else begin
            state    <= state_n;
            board    <= board_n;
            turn     <= turn_n;
            winner   <= winner_n;
            win_line <= win_line_n;
        end
    end

    always_comb begin
        state_n    = state;
        board_n    = board;
        turn_n     = turn;
        winner_n   = winner;
        win_line_n = win_line;
        case (state)
            S_PLAY: begin
                if (sel_pulse && cursor_ok && !cell_full[cursor]) begin
                    board_n[{cursor, 1'b0} +: 2] = mark;
                    state_n = S_CHECK;
                end
            end
            S_CHECK: begin
                // A win is tested before a full board, so a ninth move
                // that completes a line counts as a win, not a draw.
                if (|line_hit) begin
                    state_n    = S_WIN;
                    winner_n   = mark;
                    win_line_n = line_hit;
                end else if (&cell_full) begin
                    state_n = S_DRAW;
                end else begin
                    turn_n  = ~turn;
                    state_n = S_PLAY;
                end
            end
            default: begin
                if (sel_pulse) begin
                    board_n    = '0;
                    winner_n   = 2'b00;
                    win_line_n = '0;
                    turn_n     = 1'b0;
                    state_n    = S_PLAY;
                end
            end
        endcase
    end

    assign game_state = state;

    // ---------------- display ----------------
    assign ssd0 = cursor;
    assign ssd1 = turn ? 4'h0 : 4'hA;

    always_comb begin
        case (state)
            S_WIN:   ssd2 = 4'hE;
            S_DRAW:  ssd2 = 4'hD;
            default: ssd2 = 4'h1;
        endcase
    end

`ifdef TTT_SCORE_EN
    logic [3:0] x_wins, o_wins;
    logic       win_now;

    assign win_now = (state == S_CHECK) && (|line_hit);

    always_ff @(posedge ClkPort or posedge Reset) begin
        if (Reset) begin
            x_wins <= 4'h0;
            o_wins <= 4'h0;
        end else if (win_now) begin
            if (!turn && x_wins != 4'hF) x_wins <= x_wins + 4'h1;
            if ( turn && o_wins != 4'hF) o_wins <= o_wins + 4'h1;
        end
    end

    assign ssd3 = turn ? o_wins : x_wins;
`else
    assign ssd3 = 4'h0;
`endif

endmodule

// File: tb/tb_ttt_game_sequencer.sv
module tb_ttt_game_sequencer;

    logic        ClkPort = 1'b0;
    logic        Reset   = 1'b1;
    logic        btn_sel = 1'b0;
    logic [3:0]  cursor  = 4'd0;
    logic [17:0] board;
    logic        turn;
    logic [1:0]  game_state, winner;
    logic [7:0]  win_line;
    logic [3:0]  ssd3, ssd2, ssd1, ssd0;

    int checks = 0;
    int passes = 0;
    int chk_seen;
    logic found;

    ttt_game_sequencer #(.DB_CYCLES(4), .DB_W(3)) dut (
        .ClkPort(ClkPort), .Reset(Reset), .btn_sel(btn_sel), .cursor(cursor),
        .board(board), .turn(turn), .game_state(game_state), .winner(winner),
        .win_line(win_line), .ssd3(ssd3), .ssd2(ssd2), .ssd1(ssd1), .ssd0(ssd0)
    );

    always #5 ClkPort = ~ClkPort;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge ClkPort);
    endtask

    // Clean press on cursor c. Also counts the cycles spent in CHECK.
    task automatic press(input logic [3:0] c);
        chk_seen = 0;
        cursor   = c;
        btn_sel  = 1'b1;
        repeat (10) begin
            @(negedge ClkPort);
            if (game_state == 2'b01) chk_seen++;
        end
        btn_sel = 1'b0;
        repeat (8) begin
            @(negedge ClkPort);
            if (game_state == 2'b01) chk_seen++;
        end
    endtask

    task automatic do_reset();
        @(negedge ClkPort);
        Reset   = 1'b1;
        btn_sel = 1'b0;
        cyc(3);
        Reset = 1'b0;
        cyc(2);
    endtask

    initial begin
        // 1: reset values, then a short press below the debounce time
        cyc(2);
        chk("rst_board", board, 18'h0);
        chk("rst_state", game_state, 2'b00);
        chk("rst_turn", turn, 1'b0);
        chk("rst_winner", winner, 2'b00);
        chk("rst_winline", win_line, 8'h00);
        chk("rst_ssd", {ssd3, ssd2, ssd1}, 12'h01A);
        Reset  = 1'b0;
        cursor = 4'd4;
        cyc(2);
        btn_sel = 1'b1;
        cyc(3);
        btn_sel = 1'b0;
        cyc(10);
        chk("short_board", board, 18'h0);
        chk("short_state", game_state, 2'b00);
        chk("ssd0_cursor", ssd0, 4'd4);

        // 2: bounce, then hold; check exact latency and that exactly one commit happens
        btn_sel = 1'b0; cyc(1);
        btn_sel = 1'b1; cyc(1);
        btn_sel = 1'b0; cyc(1);
        btn_sel = 1'b1;
        cyc(6);
        chk("lat_before", board, 18'h0);
        cyc(1);
        chk("lat_commit", board, 18'h00100);
        chk("lat_check", game_state, 2'b01);
        cyc(1);
        chk("after_turn", turn, 1'b1);
        chk("after_state", game_state, 2'b00);
        chk("ssd1_o", ssd1, 4'h0);
        cursor = 4'd5;
        cyc(6);
        btn_sel = 1'b0;
        cyc(10);
        chk("one_pulse", board, 18'h00100);

        // 3: occupied square and an invalid cursor are ignored
        press(4'd4);
        chk("occ_board", board, 18'h00100);
        chk("occ_turn", turn, 1'b1);
        chk("occ_state", game_state, 2'b00);
        chk("occ_nocheck", chk_seen, 0);
        press(4'd12);
        chk("inv_board", board, 18'h00100);

        // 4: X wins on the top row
        do_reset();
        press(4'd0); press(4'd3); press(4'd1); press(4'd4);
        press(4'd2);
        chk("win_check1", chk_seen, 1);
        chk("win_state", game_state, 2'b10);
        chk("win_winner", winner, 2'b01);
        chk("win_line", win_line, 8'h01);
        chk("win_board", board, 18'h00295);
        chk("win_ssd2", ssd2, 4'hE);
        cyc(5);
        chk("win_frozen", board, 18'h00295);
        press(4'd5);
        chk("clr_board", board, 18'h0);
        chk("clr_state", game_state, 2'b00);
        chk("clr_turn", turn, 1'b0);
        chk("clr_winner", winner, 2'b00);
        chk("clr_winline", win_line, 8'h00);

        // 5: draw
        press(4'd0); press(4'd1); press(4'd2); press(4'd5); press(4'd3);
        press(4'd6); press(4'd4); press(4'd8); press(4'd7);
        chk("draw_check1", chk_seen, 1);
        chk("draw_state", game_state, 2'b11);
        chk("draw_winner", winner, 2'b00);
        chk("draw_winline", win_line, 8'h00);
        chk("draw_board", board, 18'h26959);
        chk("draw_ssd2", ssd2, 4'hD);
        press(4'd0);
        chk("draw_clr", {game_state, board}, 20'h0);

`ifdef TTT_SCORE_EN
        // 6a: sixteen X wins saturate the X tally at F
        do_reset();
        repeat (16) begin
            press(4'd0); press(4'd3); press(4'd1); press(4'd4); press(4'd2);
            press(4'd8);
        end
        chk("score_sat", ssd3, 4'hF);
`endif

        // 6b: reset asserted while in CHECK
        do_reset();
        press(4'd0);
        cursor  = 4'd5;
        btn_sel = 1'b1;
        found   = 1'b0;
        for (int i = 0; i < 14 && !found; i++) begin
            @(negedge ClkPort);
            if (game_state == 2'b01) found = 1'b1;
        end
        chk("midchk_seen", found, 1'b1);
        Reset   = 1'b1;
        btn_sel = 1'b0;
        #1;
        chk("midchk_board", board, 18'h0);
        chk("midchk_state", game_state, 2'b00);
        chk("midchk_misc", {turn, winner, win_line}, 11'h0);
        chk("midchk_ssd3", ssd3, 4'h0);
        cyc(3);
        Reset = 1'b0;
        cyc(2);
        press(4'd8);
        chk("post_rst_move", board, 18'h10000);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
